// File: rtl/hart_pkg.sv
// Shared hart definitions: data width, NOP encoding, fetch FSM states and the
// instruction buffer entry layout.
package hart_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_STOP  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic            trap;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two circular FIFO with flush, simultaneous
// push/pop at any occupancy, and an occupancy count.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 65
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push, do_pop;

   // A pop frees the slot in the same cycle, so push is legal when full and popping.
   assign do_pop  = pop && cnt != '0;
   assign do_push = push && (cnt != FULL || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      cnt <= cnt + CW'(1);
         else if (!do_push && do_pop) cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign valid = cnt != '0;
   assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, imem request/response tracking, redirect
// drain and instruction buffer. Define FETCH_MISALIGN_TRAP_EN for misaligned-target traps.
module fetch_unit
   import hart_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_ADDR      = 32'h0000_0000,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [XLEN-1:0] i_imem_rdata,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_inst_valid,
   output logic [XLEN-1:0] o_inst,
   output logic [XLEN-1:0] o_inst_pc,
   output logic            o_inst_trap,
   input  logic            i_inst_ready
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] MAX_O   = CW'(MAX_OUTSTANDING);
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

   fetch_state_e    state;
   logic [XLEN-1:0] pc, tgt, rsp_pc;
   logic [CW-1:0]   out_cnt, out_nxt, occ;
   logic            mis, trap_pend;
   logic            gnt_acc, rsp_acc, push, pop;
   fetch_entry_t    push_e, head_e;
   logic            head_vld;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign tgt = i_redirect_pc;
   assign mis = i_redirect_pc[1:0] != 2'b00;
`else
   assign tgt = i_redirect_pc & ~32'h3;
   assign mis = 1'b0;
`endif

   // Counting outstanding + buffered slots guarantees every response has room.
   assign o_imem_req  = i_rst_n && state == ST_RUN && !i_redirect && out_cnt < MAX_O
                        && ({1'b0, out_cnt} + {1'b0, occ}) < DEPTH_C;
   assign o_imem_addr = pc & ~32'h3;

   assign gnt_acc = o_imem_req & i_imem_gnt;
   assign rsp_acc = i_imem_rvalid & (out_cnt != '0);
   // Responses are in order, so the oldest outstanding request sits out_cnt words behind pc.
   assign rsp_pc  = pc - XLEN'({out_cnt, 2'b00});

   always_comb begin
      out_nxt = out_cnt;
      if (gnt_acc && !rsp_acc)      out_nxt = out_cnt + CW'(1);
      else if (!gnt_acc && rsp_acc) out_nxt = out_cnt - CW'(1);
   end

   always_comb begin
      push   = rsp_acc && state == ST_RUN && !i_redirect;
      push_e = '{inst: i_imem_rdata, pc: rsp_pc, trap: 1'b0};
      if (state == ST_DRAIN && trap_pend && out_nxt == '0 && !i_redirect) begin
         push   = 1'b1;
         push_e = '{inst: '0, pc: pc, trap: 1'b1};
      end
   end

   assign pop = head_vld & i_inst_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_RUN;
         pc        <= RESET_ADDR;
         out_cnt   <= '0;
         trap_pend <= 1'b0;
      end else begin
         out_cnt <= out_nxt;
         if (i_redirect) begin
            pc        <= tgt;
            trap_pend <= mis;
            state     <= (out_nxt != '0 || mis) ? ST_DRAIN : ST_RUN;
         end else begin
            unique case (state)
               ST_RUN: begin
                  if (gnt_acc) pc <= pc + 32'd4;
               end
               ST_DRAIN: begin
                  if (out_nxt == '0) begin
                     state     <= trap_pend ? ST_STOP : ST_RUN;
                     trap_pend <= 1'b0;
                  end
               end
               ST_STOP: begin
               end
               default: state <= ST_RUN;
            endcase
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .flush (i_redirect),
      .push  (push),
      .wdata (push_e),
      .pop   (pop),
      .rdata (head_e),
      .valid (head_vld),
      .count (occ)
   );

   assign o_inst_valid = head_vld;
   assign o_inst       = head_vld ? head_e.inst : '0;
   assign o_inst_pc    = head_vld ? head_e.pc   : '0;
   assign o_inst_trap  = head_vld & head_e.trap;

endmodule
